// File: rtl/spi_frame_pkg.sv
// Shared types and defaults for the SPI frame serializer.
package spi_frame_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_REQ = 2'd1,
      WAIT_ACK = 2'd2,
      DONE     = 2'd3
   } state_t;

   localparam logic [7:0] DEFAULT_CMD_BYTE   = 8'h02;
   localparam logic [7:0] DEFAULT_START_ADDR = 8'h00;

   // Bytes per frame: command + address + payload + padding.
   function automatic int calc_total(input int num_words, input int word_w, input int pad_bytes);
      return 2 + num_words * word_w / 8 + pad_bytes;
   endfunction

endpackage

// File: rtl/spi_byte_mux.sv
// Index-to-byte selector for a frame: command, address, payload (LSB first), then zero padding.
module spi_byte_mux #(
   parameter int         NUM_WORDS  = 8,
   parameter int         WORD_W     = 32,
   parameter logic [7:0] CMD_BYTE   = 8'h02,
   parameter logic [7:0] START_ADDR = 8'h00,
   parameter int         IDX_W      = 6
) (
   input  logic [NUM_WORDS*WORD_W-1:0] frame,
   input  logic [IDX_W-1:0]            index,
   output logic [7:0]                  byte_sel
);

   localparam int NB = NUM_WORDS * WORD_W / 8;

   always_comb begin
      byte_sel = 8'h00;
      if (index == '0) begin
         byte_sel = CMD_BYTE;
      end else if (index == IDX_W'(1)) begin
         byte_sel = START_ADDR;
      end else begin
         // Anything past the payload falls through to the zero default (padding).
         for (int i = 0; i < NB; i++) begin
            if (int'(index) == i + 2) byte_sel = frame[8*i +: 8];
         end
      end
   end

endmodule

// File: rtl/spi_frame_serializer.sv
// Frame serializer for the SPI master transmit port, with a one-deep pending buffer and drop counter.
//
// state    | meaning
// IDLE     | no frame in flight, waiting for data_ready
// WAIT_REQ | frame active, waiting for di_req to present byte[index]
// WAIT_ACK | wren high, byte held until a rising edge of write_ack
// DONE     | one-cycle frame_done, then next frame (pending/new) or IDLE
module spi_frame_serializer
   import spi_frame_pkg::*;
#(
   parameter int         NUM_WORDS  = 8,
   parameter int         WORD_W     = 32,
   parameter logic [7:0] CMD_BYTE   = DEFAULT_CMD_BYTE,
   parameter logic [7:0] START_ADDR = DEFAULT_START_ADDR,
   parameter int         PAD_BYTES  = 0
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [NUM_WORDS*WORD_W-1:0] data,
   input  logic                        data_ready,
   input  logic                        di_req,
   input  logic                        write_ack,
   input  logic                        mpu_interrupt_in,
   output logic [7:0]                  byte_out,
   output logic                        wren,
   output logic                        busy,
   output logic                        frame_done,
   output logic [15:0]                 dropped_frames,
   output logic                        mpu_interrupt_out
);

   localparam int TOTAL = calc_total(NUM_WORDS, WORD_W, PAD_BYTES);
   localparam int IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);

   state_t                      state;
   logic [IDX_W-1:0]            index;
   logic [NUM_WORDS*WORD_W-1:0] frame_reg;
   logic [NUM_WORDS*WORD_W-1:0] pending_reg;
   logic                        pending_valid;
   logic                        ack_prev;
   logic                        ack_rise;
   logic [7:0]                  sel_byte;

   assign ack_rise          = write_ack & ~ack_prev;
   assign busy              = (state != IDLE);
   assign mpu_interrupt_out = mpu_interrupt_in;

   spi_byte_mux #(
      .NUM_WORDS (NUM_WORDS),
      .WORD_W    (WORD_W),
      .CMD_BYTE  (CMD_BYTE),
      .START_ADDR(START_ADDR),
      .IDX_W     (IDX_W)
   ) u_byte_mux (
      .frame   (frame_reg),
      .index   (index),
      .byte_sel(sel_byte)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= IDLE;
         index          <= '0;
         frame_reg      <= '0;
         pending_reg    <= '0;
         pending_valid  <= 1'b0;
         ack_prev       <= 1'b0;
         byte_out       <= 8'h00;
         wren           <= 1'b0;
         frame_done     <= 1'b0;
         dropped_frames <= 16'h0000;
      end else begin
         ack_prev   <= write_ack;
         frame_done <= 1'b0;

         case (state)
            IDLE: begin
               if (data_ready) begin
                  frame_reg <= data;
                  index     <= '0;
                  state     <= WAIT_REQ;
               end
            end
            WAIT_REQ: begin
               if (di_req) begin
                  byte_out <= sel_byte;
                  wren     <= 1'b1;
                  state    <= WAIT_ACK;
               end
            end
            WAIT_ACK: begin
               if (ack_rise) begin
                  wren <= 1'b0;
                  if (index == LAST_IDX) begin
                     state      <= DONE;
                     frame_done <= 1'b1;
                  end else begin
                     index <= index + IDX_W'(1);
                     state <= WAIT_REQ;
                  end
               end
            end
            DONE: begin
               index <= '0;
               if (pending_valid) begin
                  // Pending frame goes out next; a coincident arrival refills the buffer without a drop.
                  frame_reg <= pending_reg;
                  state     <= WAIT_REQ;
                  if (data_ready) pending_reg <= data;
                  else            pending_valid <= 1'b0;
               end else if (data_ready) begin
                  frame_reg <= data;
                  state     <= WAIT_REQ;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         if (data_ready && (state == WAIT_REQ || state == WAIT_ACK)) begin
            pending_reg   <= data;
            pending_valid <= 1'b1;
            if (pending_valid && dropped_frames != 16'hFFFF)
               dropped_frames <= dropped_frames + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_spi_frame_serializer.sv
// Directed bench: a 2-word instance for framing, handshake, pending/drop and reset, and a 1-word padded instance.
module tb_spi_frame_serializer;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [63:0] data = '0;
   logic        data_ready = 1'b0;
   logic        di_req = 1'b0;
   logic        write_ack = 1'b0;
   logic        mpu_interrupt_in = 1'b0;
   logic [7:0]  byte_out;
   logic        wren, busy, frame_done, mpu_interrupt_out;
   logic [15:0] dropped_frames;

   logic [31:0] p_data = '0;
   logic        p_data_ready = 1'b0;
   logic [7:0]  p_byte_out;
   logic        p_wren, p_busy, p_frame_done, p_mpu_out;
   logic [15:0] p_dropped;

   int total = 0;
   int bad = 0;
   int fd_count = 0;

   always #5 clock = ~clock;

   spi_frame_serializer #(.NUM_WORDS(2), .WORD_W(32), .PAD_BYTES(0)) dut (
      .clock(clock), .reset(reset), .data(data), .data_ready(data_ready),
      .di_req(di_req), .write_ack(write_ack), .mpu_interrupt_in(mpu_interrupt_in),
      .byte_out(byte_out), .wren(wren), .busy(busy), .frame_done(frame_done),
      .dropped_frames(dropped_frames), .mpu_interrupt_out(mpu_interrupt_out)
   );

   spi_frame_serializer #(.NUM_WORDS(1), .WORD_W(32), .PAD_BYTES(3)) dut_pad (
      .clock(clock), .reset(reset), .data(p_data), .data_ready(p_data_ready),
      .di_req(di_req), .write_ack(write_ack), .mpu_interrupt_in(1'b0),
      .byte_out(p_byte_out), .wren(p_wren), .busy(p_busy), .frame_done(p_frame_done),
      .dropped_frames(p_dropped), .mpu_interrupt_out(p_mpu_out)
   );

   always @(negedge clock) if (frame_done === 1'b1) fd_count++;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // One di_req / write_ack transaction; returns the byte presented with wren.
   task automatic get_byte(input bit use_p, output logic [7:0] b);
      int n = 0;
      di_req = 1'b1;
      step();
      while (!(use_p ? p_wren : wren) && n < 20) begin
         step();
         n++;
      end
      di_req = 1'b0;
      check("wren_rise", use_p ? p_wren : wren, 1);
      b = use_p ? p_byte_out : byte_out;
      write_ack = 1'b1;
      step();
      check("wren_fall", use_p ? p_wren : wren, 0);
      write_ack = 1'b0;
   endtask

   // Full frame on the 2-word instance: 02, 00, then payload bytes LSB first.
   task automatic check_frame(input string tag, input logic [63:0] payload);
      logic [7:0] b;
      logic [7:0] exp;
      for (int i = 0; i < 10; i++) begin
         exp = (i == 0) ? 8'h02 : (i == 1) ? 8'h00 : payload[8*(i-2) +: 8];
         get_byte(1'b0, b);
         check(tag, {24'h0, b}, {24'h0, exp});
      end
   endtask

   initial begin
      logic [7:0] b;
      logic [7:0] exp_basic [10];
      logic [7:0] exp_pad [9];
      int fd_before;

      exp_basic = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      exp_pad   = '{8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00, 8'h00, 8'h00};

      // Reset state
      step();
      step();
      check("rst_wren", wren, 0);
      check("rst_busy", busy, 0);
      check("rst_byte", byte_out, 0);
      check("rst_done", frame_done, 0);
      check("rst_drop", dropped_frames, 0);
      reset = 1'b0;
      step();

      // Basic frame
      data = {32'h88776655, 32'h44332211};
      data_ready = 1'b1;
      step();
      data_ready = 1'b0;
      check("basic_busy", busy, 1);
      for (int i = 0; i < 10; i++) begin
         get_byte(1'b0, b);
         check("basic_byte", {24'h0, b}, {24'h0, exp_basic[i]});
         if (i < 9) check("basic_no_done", frame_done, 0);
      end
      check("basic_done", frame_done, 1);
      step();
      check("basic_done_pulse", frame_done, 0);
      check("basic_idle", busy, 0);
      check("basic_fd_count", fd_count, 1);

      // Handshake hold, and a held-high write_ack must not advance
      data_ready = 1'b1;
      step();
      data_ready = 1'b0;
      di_req = 1'b1;
      step();
      di_req = 1'b0;
      check("hold_wren", wren, 1);
      check("hold_byte", byte_out, 8'h02);
      for (int i = 0; i < 5; i++) begin
         step();
         check("hold_wren_stable", wren, 1);
         check("hold_byte_stable", byte_out, 8'h02);
      end
      write_ack = 1'b1;
      step();
      check("hold_ack_fall", wren, 0);
      di_req = 1'b1;
      step();
      di_req = 1'b0;
      check("hold_addr_byte", byte_out, 8'h00);
      step();
      step();
      check("hold_no_adv_wren", wren, 1);
      check("hold_no_adv_byte", byte_out, 8'h00);
      write_ack = 1'b0;
      step();
      write_ack = 1'b1;
      step();
      check("hold_second_rise", wren, 0);
      write_ack = 1'b0;
      for (int i = 2; i < 10; i++) begin
         get_byte(1'b0, b);
         check("hold_byte_seq", {24'h0, b}, {24'h0, exp_basic[i]});
      end
      step();
      check("hold_idle", busy, 0);

      // Pending and drop: B overwritten by C during frame A
      data = 64'hA7A6A5A4_A3A2A1A0;
      data_ready = 1'b1;
      step();
      data_ready = 1'b0;
      get_byte(1'b0, b);
      check("pend_a0", b, 8'h02);
      get_byte(1'b0, b);
      check("pend_a1", b, 8'h00);
      data = 64'hBBBBBBBB_BBBBBBBB;
      data_ready = 1'b1;
      step();
      data = 64'h01234567_89ABCDEF;
      step();
      data_ready = 1'b0;
      data = 64'h0;
      check("pend_drop", dropped_frames, 1);
      for (int i = 2; i < 10; i++) begin
         get_byte(1'b0, b);
         check("pend_a_payload", {24'h0, b}, {24'h0, 8'hA0 + 8'(i - 2)});
      end
      check("pend_a_done", frame_done, 1);
      step();
      check("pend_b2b_busy", busy, 1);
      check("pend_b2b_done_clr", frame_done, 0);
      check_frame("pend_c_byte", 64'h01234567_89ABCDEF);
      step();
      check("pend_idle", busy, 0);
      check("pend_drop_final", dropped_frames, 1);
      check("pend_fd_count", fd_count, 4);

      // Padding instance
      p_data = 32'hDEADBEEF;
      p_data_ready = 1'b1;
      step();
      p_data_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         get_byte(1'b1, b);
         check("pad_byte", {24'h0, b}, {24'h0, exp_pad[i]});
      end
      check("pad_done", p_frame_done, 1);
      step();
      check("pad_idle", p_busy, 0);

      // Mid-frame reset with a frame pending
      data = 64'hFEDCBA98_76543210;
      data_ready = 1'b1;
      step();
      data_ready = 1'b0;
      for (int i = 0; i < 4; i++) get_byte(1'b0, b);
      check("rstm_4th", b, 8'h32);
      data = 64'h55555555_55555555;
      data_ready = 1'b1;
      step();
      data_ready = 1'b0;
      di_req = 1'b1;
      step();
      di_req = 1'b0;
      check("rstm_pre_wren", wren, 1);
      fd_before = fd_count;
      reset = 1'b1;
      step();
      check("rstm_wren", wren, 0);
      check("rstm_busy", busy, 0);
      check("rstm_byte", byte_out, 0);
      check("rstm_drop", dropped_frames, 0);
      reset = 1'b0;
      step();
      step();
      step();
      check("rstm_stay_idle", busy, 0);
      check("rstm_no_done", fd_count, fd_before);
      data = 64'h0F0E0D0C_0B0A0908;
      data_ready = 1'b1;
      step();
      data_ready = 1'b0;
      check_frame("rstm_fresh", 64'h0F0E0D0C_0B0A0908);
      step();
      check("rstm_pending_gone", busy, 0);

      // Saturation: data_ready held with no di_req keeps the frame in WAIT_REQ
      data_ready = 1'b1;
      for (int i = 0; i < 101; i++) step();
      check("sat_partial", dropped_frames, 99);
      for (int i = 0; i < 65439; i++) step();
      data_ready = 1'b0;
      check("sat_full", dropped_frames, 16'hFFFF);
      step();
      check("sat_hold", dropped_frames, 16'hFFFF);

      // Interrupt pass-through, same cycle
      for (int i = 0; i < 6; i++) begin
         mpu_interrupt_in = (i % 2 == 0);
         #1;
         check("mpu_pass", mpu_interrupt_out, (i % 2 == 0) ? 1 : 0);
         #2;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_frame_serializer.md
Name: spi_frame_serializer

Overview:
- Parametrised byte serializer feeding the SPI master's transmit port (di_req / wren / write_ack handshake).
- Snapshots a frame of NUM_WORDS sensor words and emits, in order:
  - a command byte,
  - a start-address byte,
  - the payload bytes, least-significant byte first,
  - optional zero padding.
- Adds a one-deep pending-frame buffer, a dropped-frame counter and per-frame status.
- Sits between the lighthouse sensor aggregator and the SPI slave link to the ESP; the MPU interrupt passes straight through.

Parameters:
- NUM_WORDS, 8, number of sensor words per frame.
- WORD_W, 32, bits per word; must be a multiple of 8.
- CMD_BYTE, 8'h02, first byte of every frame.
- START_ADDR, 8'h00, second byte of every frame (ESP write address).
- PAD_BYTES, 0, number of trailing 8'h00 bytes after the payload.
- TOTAL (localparam), 2 + NUM_WORDS*WORD_W/8 + PAD_BYTES; byte index width is clog2(TOTAL).

Ports:
- clock  in  1  single system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- data  in  NUM_WORDS*WORD_W  frame payload; word k occupies bits [k*WORD_W +: WORD_W].
- data_ready  in  1  single-cycle strobe: data is valid this cycle.
- di_req  in  1  SPI master requests the next transmit byte.
- write_ack  in  1  SPI master has accepted the byte; its rising edge is what counts.
- mpu_interrupt_in  in  1  MPU interrupt line.
- byte_out  out  8  transmit byte.
- wren  out  1  byte_out valid; write request to the SPI master.
- busy  out  1  high while a frame is being sent (any state other than IDLE).
- frame_done  out  1  one-cycle pulse after the last byte of a frame is acknowledged.
- dropped_frames  out  16  saturating count of frames overwritten in the pending buffer.
- mpu_interrupt_out  out  1  combinational copy of mpu_interrupt_in.

Behaviour:
- Reset (synchronous, while reset=1):
  - state=IDLE, index=0, pending_valid=0.
  - byte_out=0, wren=0, frame_done=0, dropped_frames=0.
  - ack_prev=0, frame/pending registers cleared.
  - Reset mid-frame abandons the frame and discards any pending frame; no frame_done pulse.
- Edge detect: ack_prev is the registered write_ack; ack_rise = write_ack & ~ack_prev. A rising edge seen outside WAIT_ACK is ignored.
- IDLE:
  - On data_ready: frame_reg <= data, index <= 0, go to WAIT_REQ.
  - wren stays 0.
- WAIT_REQ:
  - On di_req=1: byte_out <= sel(index), wren <= 1, go to WAIT_ACK.
  - So wren rises one cycle after di_req is seen.
- WAIT_ACK:
  - wren and byte_out are held stable.
  - On ack_rise: wren <= 0.
  - If index == TOTAL-1, go to DONE; otherwise index <= index+1 and go to WAIT_REQ.
  - di_req is not sampled in WAIT_ACK; a di_req arriving in the same cycle as ack_rise is acted on only if it is still high in WAIT_REQ.
- DONE (one cycle): frame_done=1, then:
  - pending_valid=1: frame_reg <= pending_reg, pending_valid <= 0, index <= 0, go to WAIT_REQ. If data_ready is also high this cycle, the new data goes into pending_reg, pending_valid stays 1, and no drop is counted.
  - pending_valid=0 with data_ready: load data directly into frame_reg and go to WAIT_REQ.
  - Otherwise go to IDLE.
- sel(i):
  - i=0 gives CMD_BYTE; i=1 gives START_ADDR.
  - 2 <= i < 2+NB, where NB = NUM_WORDS*WORD_W/8: byte (i-2) of frame_reg, i.e. frame_reg[8*(i-2) +: 8].
  - Higher i gives 8'h00 (padding).
- data_ready while busy (WAIT_REQ / WAIT_ACK):
  - pending_reg <= data and pending_valid <= 1.
  - If pending_valid was already 1, the newest frame wins and dropped_frames increments, saturating at 16'hFFFF.
- frame_reg is never modified mid-frame, so payload bytes always come from a single snapshot.
- Throughput: no idle cycles between frames when a frame is pending; DONE costs one cycle.

Decomposition:
- Package spi_frame_pkg: state enum (IDLE, WAIT_REQ, WAIT_ACK, DONE), default CMD_BYTE/START_ADDR constants, and a function computing TOTAL.
- One natural sub-module, spi_byte_mux: a combinational index-to-byte selector (command / address / payload / pad), kept separate so it can be verified exhaustively.
- The FSM, pending buffer and counter stay in the top module.

Test Plan:
- Basic frame (NUM_WORDS=2, PAD_BYTES=0, words 0x44332211 and 0x88776655): pulse data_ready, serve di_req then write_ack per byte -> bytes 02,00,11,22,33,44,55,66,77,88; a single frame_done pulse after the 10th ack; busy returns to 0.
- Handshake hold: delay write_ack 5 cycles after wren rises -> wren and byte_out held constant; a second write_ack pulse with no falling edge in between does not advance index.
- Pending and drop: start frame A, then send frames B and C mid-frame -> A completes, then C is sent (B is overwritten), dropped_frames=1, and frames are back-to-back (DONE then WAIT_REQ).
- Padding (PAD_BYTES=3, NUM_WORDS=1, word 0xDEADBEEF) -> bytes 02,00,EF,BE,AD,DE,00,00,00; TOTAL=9.
- Mid-frame reset: assert reset after the 4th byte with a frame pending -> next cycle wren=0, busy=0, byte_out=0, dropped_frames=0, no frame_done; the next data_ready starts a fresh frame at CMD_BYTE.
- Saturation: force 65537 overwrites -> dropped_frames=16'hFFFF; mpu_interrupt_out follows mpu_interrupt_in in the same cycle throughout.
